// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package serial_sub_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_slice_4b.sv
// Combinational 4-bit subtractor slice: d = x - y - bi, bo = borrow out of bit 3.
module sub_slice_4b
    import serial_sub_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bi,
    output logic [3:0] d,
    output logic       bo
);

    logic [NIB_W:0] brw_chain;

    assign brw_chain[0] = bi;

    // Full-subtractor cell per bit; borrow when x < y + borrow_in.
    for (genvar i = 0; i < NIB_W; i++) begin : g_fs
        assign d[i]           = x[i] ^ y[i] ^ brw_chain[i];
        assign brw_chain[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw_chain[i]);
    end

    assign bo = brw_chain[NIB_W];

endmodule

// File: rtl/serial_sub_16b.sv
// Nibble-serial subtractor, one nibble per cycle, valid/ready on both sides.
// Define SERIAL_SUB_SAT_EN to clamp diff to zero in DONE when the result borrows.
module serial_sub_16b
    import serial_sub_pkg::*;
#(
    parameter int NIB = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NIB_W*NIB-1:0]   a,
    input  logic [NIB_W*NIB-1:0]   b,
    input  logic                   bin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NIB_W*NIB-1:0]   diff,
    output logic                   bout,
    output logic                   busy
);

    localparam int W     = NIB_W * NIB;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               brw_q, brw_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       diff_q, diff_d;
    logic               bout_q, bout_d;

    logic [NIB_W-1:0]   slice_x, slice_y, slice_d;
    logic               slice_bo;
    int                 nib_lsb;

    assign nib_lsb = int'(cnt_q) * NIB_W;
    assign slice_x = a_q[nib_lsb +: NIB_W];
    assign slice_y = b_q[nib_lsb +: NIB_W];

    sub_slice_4b u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .bi (brw_q),
        .d  (slice_d),
        .bo (slice_bo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    diff_d  = '0;
                    bout_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[nib_lsb +: NIB_W] = slice_d;
                brw_d = slice_bo;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    bout_d  = slice_bo;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Return to IDLE only; a new accept needs one more cycle.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign bout      = bout_q;

`ifdef SERIAL_SUB_SAT_EN
    assign diff = ((state_q == DONE) && bout_q) ? '0 : diff_q;
`else
    assign diff = diff_q;
`endif

endmodule

// File: tb/tb_serial_sub_16b.sv
// Scoreboard bench for serial_sub_16b: directed vectors, queue-based monitor.
module tb_serial_sub_16b;

    localparam int NIB = 4;
    localparam int W   = 16;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bi;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         bin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, bout, busy;
    logic [W-1:0] diff;

    serial_sub_16b #(.NIB(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];
    int         acc_q[$];
    int         last_acc = -1;
    logic       chk_spacing = 1'b0;

    vec_t vecs[10] = '{
        '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0},
        '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1},
        '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0},
        '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1},
        '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1},
        '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0},
        '{16'h1000, 16'h0FFF, 1'b0, 16'h0001, 1'b0},
        '{16'h5555, 16'hAAAA, 1'b0, 16'hAAAB, 1'b1},
        '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0},
        '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1}
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] sat(input logic [W-1:0] d, input logic bo);
`ifdef SERIAL_SUB_SAT_EN
        return bo ? '0 : d;
`else
        if (bo) return d;
        return d;
`endif
    endfunction

    // Monitor: latency on each out_valid rise, result compare on each handshake.
    logic       ov_prev = 1'b0;
    int         mon_t;
    logic [W:0] mon_e;
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!ov_prev) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    mon_t = acc_q.pop_front();
                    check("latency", cyc - mon_t, NIB);
                end
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {31'd0, out_valid}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("diff", {16'd0, diff}, {16'd0, mon_e[W-1:0]});
                    check("bout", {31'd0, bout}, {31'd0, mon_e[W]});
                end
            end
        end
        ov_prev = rst_n && out_valid;
    end

    task automatic issue(input vec_t v);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        a = v.a; b = v.b; bin = v.bi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_q.push_back(cyc);
        exp_q.push_back({v.bo, sat(v.d, v.bo)});
        if (chk_spacing && last_acc >= 0) check("accept_spacing", cyc - last_acc, NIB + 2);
        last_acc = cyc;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_diff", {16'd0, diff}, 32'd0);
        check("rst_bout", {31'd0, bout}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i]);
            wait_drain();
        end

        // Back-to-back with out_ready held high.
        chk_spacing = 1'b1;
        last_acc = -1;
        for (int i = 0; i < 5; i++) issue(vecs[i]);
        wait_drain();
        chk_spacing = 1'b0;

        // Stall in DONE while new operands are offered.
        out_ready = 1'b0;
        issue(vecs[5]);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold_reach_done", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            a = vecs[6].a; b = vecs[6].b; bin = vecs[6].bi; in_valid = 1'b1;
            @(negedge clk);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_diff", {16'd0, diff}, {16'd0, sat(vecs[5].d, vecs[5].bo)});
            check("hold_bout", {31'd0, bout}, {31'd0, vecs[5].bo});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hold_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_hold_out_valid", {31'd0, out_valid}, 32'd0);
        issue(vecs[6]);
        wait_drain();

        // Reset two cycles into RUN discards the operation.
        issue(vecs[7]);
        @(posedge clk); #1;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        acc_q.delete();
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_diff", {16'd0, diff}, 32'd0);
        check("midrst_bout", {31'd0, bout}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("no_result_after_reset", {31'd0, out_valid}, 32'd0);
        end
        issue(vecs[8]);
        wait_drain();
        issue(vecs[9]);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_sub_16b.md
SERIAL_SUB_16B -- requirements
Module: serial_sub_16b

Interface
REQ-001 SHALL have parameter NIB, default 4, giving the number of 4-bit nibbles; the operand width W = 4*NIB.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: operands a, b and bin are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have ports a and b, input, W bits each: minuend and subtrahend.
REQ-007 SHALL have port bin, input, 1 bit: borrow-in.
REQ-008 SHALL have port out_valid, output, 1 bit: diff and bout are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-010 SHALL have port diff, output, W bits: the difference a - b - bin.
REQ-011 SHALL have port bout, output, 1 bit: borrow-out of the MSB nibble.
REQ-012 SHALL have port busy, output, 1 bit: the block is in the RUN state.

Function
REQ-013 SHALL use an FSM with states IDLE, RUN and DONE, plus nibble counter cnt (ceil(log2 NIB) bits) and borrow register brw.
REQ-014 SHALL drive in_ready = (state==IDLE), busy = (state==RUN) and out_valid = (state==DONE), all decoded from registered state only.
REQ-015 In IDLE, on in_valid & in_ready, SHALL latch a and b, set brw <= bin, clear cnt and the result register, and go to RUN.
REQ-016 In RUN, each cycle SHALL compute nibble cnt as a[cnt] - b[cnt] - brw, write the 4-bit result into diff nibble cnt, load brw with that nibble's borrow, and increment cnt.
REQ-017 SHALL go from RUN to DONE on the cycle that processes nibble NIB-1; bout = final brw.
REQ-018 Latency SHALL be exactly NIB cycles: out_valid rises NIB rising edges after the acceptance edge.
REQ-019 In DONE, diff and bout SHALL hold stable until out_valid & out_ready, then the FSM SHALL go to IDLE.
REQ-020 There SHALL be no same-cycle accept on DONE->IDLE; the sustained throughput is one result per NIB+2 cycles.
REQ-021 in_valid SHALL be ignored outside IDLE; latched operands SHALL be unaffected by input changes during RUN or DONE.
REQ-022 Arithmetic SHALL be modulo 2^W; bout=1 exactly when a < b + bin, treating the operands as unsigned.

Reset
REQ-023 On rst_n low, at any time including mid-RUN, SHALL force state=IDLE, cnt=0, brw=0, diff=0, bout=0 and operand registers =0.
REQ-024 Reset values of the outputs SHALL be in_ready=1, out_valid=0, busy=0, diff=0, bout=0; an in-flight operation is discarded with no partial result emitted.

Configuration
REQ-025 Macro SERIAL_SUB_SAT_EN, when defined, SHALL make diff read all-zeros in DONE whenever bout=1 (unsigned saturation); bout still reports the true borrow.
REQ-026 Without SERIAL_SUB_SAT_EN, diff SHALL be the raw modulo-2^W result; there SHALL be no saturation logic.

Structure
REQ-027 Package serial_sub_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the constant NIB_W=4.
REQ-028 SHALL instantiate exactly one combinational sub-module, sub_slice_4b (inputs x[3:0], y[3:0], bi; outputs d[3:0], bo), built from borrow-chained full-subtractor cells; all sequencing stays in serial_sub_16b.

Verification
REQ-029 a=16'h1234, b=16'h0234, bin=0 -> after 4 cycles out_valid=1, diff=16'h1000, bout=0.
REQ-030 a=16'h0000, b=16'h0001, bin=0 -> diff=16'hFFFF, bout=1; with SERIAL_SUB_SAT_EN, diff=16'h0000, bout=1.
REQ-031 a=16'h8000, b=16'h0000, bin=1 -> borrow ripples across all 4 nibbles; diff=16'h7FFF, bout=0.
REQ-032 Hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> diff held, in_ready=0, new operands not taken; after out_ready=1, IDLE, then the new operands are accepted.
REQ-033 Assert rst_n=0 two cycles into RUN -> out_valid=0, busy=0, in_ready=1, diff=0 immediately; no result is emitted; the next operation is correct.
REQ-034 Back-to-back with out_ready=1 -> accepts are spaced exactly 6 cycles apart and results appear in order.
